// File: rtl/tdc_accum_pkg.sv
// tdc_accum_pkg: shared state enum, word-count constant and sample/mean helpers for tdc_hw_accum.
package tdc_accum_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, READ} state_e;
  localparam int WORDS_PER_CH = 3;
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
  function automatic int sat(input int v, input int n);
    return (v > n) ? n : v;
  endfunction
  function automatic int round_mean(input int sum, input int log2_s);
    return (sum + (1 << (log2_s - 1))) >> log2_s;
  endfunction
endpackage

// File: rtl/tdc_hw_accum_chan_stats.sv
// tdc_hw_chan_stats: per-channel sum/min/max/count over 2^LOG2_S saturated hw samples.
module tdc_hw_chan_stats
  import tdc_accum_pkg::*;
#(
  parameter int N = 64,
  parameter int LOG2_S = 4,
  parameter int HW_W = $clog2(N) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            acc,
  input  logic [HW_W-1:0] hw,
  output logic            done,
  output logic [HW_W-1:0] mean,
  output logic [HW_W-1:0] mn,
  output logic [HW_W-1:0] mx
);
  localparam int SW = HW_W + LOG2_S;
  logic [SW-1:0] sum_q, sum_d;
  logic [HW_W-1:0] min_q, min_d, max_q, max_d, v;
  logic [LOG2_S-1:0] cnt_q, cnt_d;
  logic done_q, done_d, take;
  always_comb begin
    v = HW_W'(sat(int'(hw), N));
    take = acc && !done_q;
    sum_d = clr ? '0 : take ? sum_q + SW'(v) : sum_q;
    min_d = clr ? '1 : (take && v < min_q) ? v : min_q;
    max_d = clr ? '0 : (take && v > max_q) ? v : max_q;
    cnt_d = clr ? '0 : take ? cnt_q + 1'b1 : cnt_q;
    done_d = clr ? 1'b0 : (take && &cnt_q) ? 1'b1 : done_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      min_q <= '1;
      max_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      min_q <= min_d;
      max_q <= max_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
    end
  end
  assign done = done_q;
  assign mn = min_q;
  assign mx = max_q;
  assign mean = HW_W'(round_mean(int'(sum_q), LOG2_S));
endmodule

// File: rtl/tdc_hw_accum.sv
// tdc_hw_accum: multi-channel TDC hw statistics engine streaming mean/min/max over a ready/valid bus.
// Optional ACCUM timeout and leading status word with macro TDC_HW_ACCUM_TIMEOUT_EN.
module tdc_hw_accum
  import tdc_accum_pkg::*;
#(
  parameter int N = 64,
  parameter int N_CH = 2,
  parameter int LOG2_S = 4,
  parameter int OUT_W = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            start,
  input  logic [N_CH*($clog2(N)+1)-1:0]   hw_in,
  input  logic [N_CH-1:0]                 hw_val,
  output logic [OUT_W-1:0]                out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy
);
  localparam int HW_W = $clog2(N) + 1;
`ifdef TDC_HW_ACCUM_TIMEOUT_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif
  localparam int NW = WORDS_PER_CH * N_CH + OFF;
  localparam int IW = idx_w(NW);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] out_data_q, out_data_d, word;
  logic out_valid_q, out_valid_d, clr, load, to_hit;
  logic [N_CH-1:0] done;
  logic [HW_W-1:0] mean_w [N_CH];
  logic [HW_W-1:0] min_w [N_CH];
  logic [HW_W-1:0] max_w [N_CH];
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    tdc_hw_chan_stats #(.N(N), .LOG2_S(LOG2_S), .HW_W(HW_W)) u_stats (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .acc(hw_val[c] && en && state_q == ACCUM),
      .hw(hw_in[c*HW_W +: HW_W]), .done(done[c]),
      .mean(mean_w[c]), .mn(min_w[c]), .mx(max_w[c])
    );
  end
`ifdef TDC_HW_ACCUM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cyc_q, cyc_d;
  logic to_q, to_d;
  always_comb begin
    cyc_d = (state_q == ACCUM) ? cyc_q + 1'b1 : '0;
    to_hit = state_q == ACCUM && cyc_q == CW'(TIMEOUT_CYC - 1);
    to_d = clr ? 1'b0 : (to_hit && !(&done)) ? 1'b1 : to_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      to_q <= 1'b0;
    end else begin
      cyc_q <= cyc_d;
      to_q <= to_d;
    end
  end
`else
  assign to_hit = TIMEOUT_CYC < 0;
`endif
  // Output word is registered: first word appears one cycle after entering READ.
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    out_valid_d = out_valid_q;
    clr = 1'b0;
    load = 1'b0;
    case (state_q)
      IDLE: if (start && en) begin
        clr = 1'b1;
        state_d = ACCUM;
      end
      ACCUM: if (&done || to_hit) begin
        state_d = READ;
        idx_d = '0;
      end
      READ: if (!out_valid_q) begin
        out_valid_d = 1'b1;
        load = 1'b1;
      end else if (out_ready) begin
        if (idx_q == IW'(NW - 1)) begin
          out_valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
          load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    word = '0;
`ifdef TDC_HW_ACCUM_TIMEOUT_EN
    if (idx_d == '0) word = OUT_W'({to_q, done});
`endif
    for (int c = 0; c < N_CH; c++)
      for (int k = 0; k < WORDS_PER_CH; k++)
        if (int'(idx_d) == OFF + WORDS_PER_CH * c + k)
          word = OUT_W'(k == 0 ? mean_w[c] : k == 1 ? min_w[c] : max_w[c]);
    out_data_d = load ? word : out_valid_d ? out_data_q : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
  end
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign busy = state_q != IDLE;
endmodule

// File: doc/tdc_hw_accum.md
Name: tdc_hw_accum

Overview:
Multi-channel statistics engine for delay-line TDC hamming-weight samples. It accepts per-channel hw/valid pulses and collects 2^LOG2_S samples per channel. It then streams mean/min/max per channel over one narrow ready/valid output bus. It sits between N_CH tdc_top instances and the 8-bit pin bus, replacing raw single-shot readout.

Parameters:
N, 64, delay-line length; HW_W = $clog2(N)+1 (localparam, derived)
N_CH, 2, number of TDC channels
LOG2_S, 4, log2 of samples per channel per run (>=1)
OUT_W, 8, output word width; must be >= HW_W and >= N_CH+1
TIMEOUT_CYC, 4096, ACCUM timeout in clk cycles (used only with the macro)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; low pauses sample acceptance
start  in  1  run request, sampled in IDLE only
hw_in  in  N_CH*HW_W  packed hw samples, channel c at [c*HW_W +: HW_W]
hw_val  in  N_CH  per-channel sample strobe
out_data  out  OUT_W  result word, zero-extended
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts word
busy  out  1  high in ACCUM or READ

Behaviour:
- Reset state: IDLE, out_valid=0, out_data=0, busy=0, sums=0, counts=0, min=all-ones(HW_W), max=0. Reset mid-run aborts immediately; no partial output is produced.
- States: IDLE -> ACCUM -> READ -> IDLE.
- IDLE: on start&en, clear all channel stats and go to ACCUM. busy=1 from the next cycle.
- ACCUM: channel c accepts a sample when hw_val[c]&en&!done[c].
  - Sample value = min(hw_in_c, N); values > N saturate to N.
  - Accept does: sum+=v, min=min(min,v), max=max(max,v), count++.
  - done[c] sets on the 2^LOG2_S-th accept; later strobes are ignored.
  - When all done bits are set -> READ on the next edge.
  - start is ignored outside IDLE. A hw_val in the same cycle as the accepted start is not counted.
- Mean = (sum + 2^(LOG2_S-1)) >> LOG2_S (round half up); always <= N. sum width = HW_W+LOG2_S.
- READ: words in order ch0 mean, ch0 min, ch0 max, ch1 mean, ... (3*N_CH words).
  - out_valid=1 throughout READ.
  - out_data changes only after a handshake (out_valid&out_ready). It is held stable under backpressure.
  - After the last handshake: out_valid=0 and state IDLE on the same edge.
- Latency: the final sample is accepted at edge k; the first word is valid after edge k+2.
- en low in READ does not stall the readout.

Optional Feature:
Macro TDC_HW_ACCUM_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in ACCUM. Reaching TIMEOUT_CYC forces READ.
  - READ prepends a status word {.., timeout_flag at bit N_CH, done[N_CH-1:0]}, giving 3*N_CH+1 words.
  - Channels that did not finish report their raw running stats, and their done bit is 0.
- Undefined: no counter, no status word. ACCUM waits indefinitely.

Decomposition:
- Package tdc_accum_pkg holds:
  - the state enum (IDLE, ACCUM, READ)
  - the word-index width function
  - the words-per-channel constant (3)
  - the saturate/round helper functions
- Sub-module tdc_hw_chan_stats handles one channel: sum/min/max/count/done, clear and accept inputs, mean output. It is instantiated N_CH times via generate.

Test Plan:
Defaults N=64, N_CH=2, LOG2_S=4, OUT_W=8.
1. ch0 16×32, ch1 16×10, out_ready=1 -> words 32,32,32,10,10,10; busy drops after the last word.
2. ch0 8×3 then 8×4 (sum 56) -> mean (56+8)>>4=4, min 3, max 4.
3. Hold out_ready=0 for 5 cycles on word 1 -> out_data constant, no word skipped, 6 words total.
4. ch0 one sample 100, 15×20 -> max=64 (saturated), min=20, mean=(64+300+8)>>4=23.
5. Extra ch0 strobes after 16, a start pulse during ACCUM, and en=0 with strobes -> ignored; results unchanged.
6. rst_n low mid-ACCUM -> all outputs reset at once; new run completes correctly. With the macro: only ch0 fed, TIMEOUT_CYC=64 -> status word 0x05 (timeout flag, done=01), then 6 words.
